hpdcache_sram_req_ctrl: RTL and testbench



---
 rtl/hpdcache_sram_ctrl_pkg.sv | 16 +
 rtl/hpdcache_sram_rsp_fifo.sv | 49 ++++
 rtl/hpdcache_sram_req_ctrl.sv | 125 ++++++++++++
 tb/tb_hpdcache_sram_req_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_sram_ctrl_pkg.sv
// Shared types and constants for the HPDcache SRAM request controller.
package hpdcache_sram_ctrl_pkg;

  typedef enum logic {
    INIT,
    RUN
  } ctrl_state_e;

  localparam int RSP_FIFO_DEPTH_DFLT = 3;

  // Bits needed to hold an occupancy count from 0 to depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hpdcache_sram_rsp_fifo.sv
// Read-response FIFO: circular buffer with registered occupancy, no bypass.
module hpdcache_sram_rsp_fifo
  import hpdcache_sram_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = RSP_FIFO_DEPTH_DFLT,
  localparam int OCC_W    = occ_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic                 valid,
  output logic [DATA_SIZE-1:0] rdata,
  output logic [OCC_W-1:0]     occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [OCC_W-1:0]     occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop)      occ_q <= occ_q + OCC_W'(1);
      else if (!push && pop) occ_q <= occ_q - OCC_W'(1);
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign rdata     = mem_q[rd_ptr_q];
  assign valid     = (occ_q != '0);
  assign occupancy = occ_q;

endmodule

// File: rtl/hpdcache_sram_req_ctrl.sv
// Request sequencer for a 1RW byte-enable SRAM macro with in-order read responses.
// HPDCACHE_SRAM_INIT_EN adds a post-reset zero-fill sweep (INIT: sweeping | RUN: serving requests).
module hpdcache_sram_req_ctrl
  import hpdcache_sram_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE      = 0,
  parameter int DATA_SIZE      = 0,
  parameter int DEPTH          = 2 ** ADDR_SIZE,
  parameter int RSP_FIFO_DEPTH = RSP_FIFO_DEPTH_DFLT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_SIZE-1:0]   req_addr,
  input  logic [DATA_SIZE-1:0]   req_wdata,
  input  logic [DATA_SIZE/8-1:0] req_be,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_SIZE-1:0]   rsp_rdata,
  output logic                   init_done,
  output logic                   sram_cs,
  output logic                   sram_we,
  output logic [ADDR_SIZE-1:0]   sram_addr,
  output logic [DATA_SIZE-1:0]   sram_wdata,
  output logic [DATA_SIZE/8-1:0] sram_wbyteenable,
  input  logic [DATA_SIZE-1:0]   sram_rdata
);

  localparam int OCC_W = occ_width(RSP_FIFO_DEPTH);

  ctrl_state_e          state_q;
  logic                 sweep_active;
  logic [ADDR_SIZE-1:0] sweep_addr;
  logic                 rd_inflight_q;
  logic [OCC_W-1:0]     occ;
  logic                 fifo_valid;
  logic                 credit_ok;
  logic                 accept;

`ifdef HPDCACHE_SRAM_INIT_EN
  localparam int SW = ADDR_SIZE + 1;
  localparam logic [SW-1:0] SWEEP_LAST = SW'(DEPTH - 1);

  ctrl_state_e   state_d;
  logic [SW-1:0] sweep_cnt_q;
  logic [SW-1:0] sweep_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  // Counter parks on the last address; leaving INIT is what ends the sweep.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    if (state_q == INIT) begin
      if (sweep_cnt_q == SWEEP_LAST) state_d = RUN;
      else                           sweep_cnt_d = sweep_cnt_q + SW'(1);
    end
  end

  assign sweep_active = (state_q == INIT) && !rst;
  assign sweep_addr   = sweep_cnt_q[ADDR_SIZE-1:0];
`else
  assign state_q      = RUN;
  assign sweep_active = 1'b0;
  assign sweep_addr   = '0;
`endif

  assign init_done = (state_q == RUN) && !rst;
  // Credits count both queued data and the read whose data lands next cycle.
  assign credit_ok = (int'(occ) + int'(rd_inflight_q)) < RSP_FIFO_DEPTH;
  assign req_ready = init_done && credit_ok;
  assign accept    = req_valid && req_ready;

  always_comb begin
    sram_cs          = 1'b0;
    sram_we          = 1'b0;
    sram_addr        = '0;
    sram_wdata       = '0;
    sram_wbyteenable = '0;
    if (sweep_active) begin
      sram_cs          = 1'b1;
      sram_we          = 1'b1;
      sram_addr        = sweep_addr;
      sram_wbyteenable = '1;
    end else if (accept) begin
      sram_cs          = 1'b1;
      sram_we          = req_we;
      sram_addr        = req_addr;
      sram_wdata       = req_wdata;
      sram_wbyteenable = req_we ? req_be : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_inflight_q <= 1'b0;
    else     rd_inflight_q <= accept && !req_we;
  end

  hpdcache_sram_rsp_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_inflight_q),
    .push_data (sram_rdata),
    .pop       (fifo_valid && rsp_ready),
    .valid     (fifo_valid),
    .rdata     (rsp_rdata),
    .occupancy (occ)
  );

  assign rsp_valid = fifo_valid;

endmodule

// File: tb/tb_hpdcache_sram_req_ctrl.sv
// Self-checking bench for hpdcache_sram_req_ctrl with a behavioural SRAM and reference model.
module tb_hpdcache_sram_req_ctrl;

  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int DEP = 16;
  localparam int FD  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [BW-1:0] sram_wbyteenable;
  logic [DW-1:0] sram_rdata;

  always #5 clk = ~clk;

  hpdcache_sram_req_ctrl #(
    .ADDR_SIZE      (AW),
    .DATA_SIZE      (DW),
    .DEPTH          (DEP),
    .RSP_FIFO_DEPTH (FD)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_be           (req_be),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .init_done        (init_done),
    .sram_cs          (sram_cs),
    .sram_we          (sram_we),
    .sram_addr        (sram_addr),
    .sram_wdata       (sram_wdata),
    .sram_wbyteenable (sram_wbyteenable),
    .sram_rdata       (sram_rdata)
  );

  // Behavioural SRAM macro, seeded with random power-up contents.
  logic [DW-1:0] seed [DEP];
  logic [DW-1:0] sram_mem [DEP];
  logic          seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEP; i++) sram_mem[i] <= seed[i];
      seeded <= 1'b1;
    end else if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++)
          if (sram_wbyteenable[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Reference model: memory image plus queue of accepted, not yet consumed reads.
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [DEP];
  bit            init_exp = 1'b0;
  int            cyc = 0;
  int            n_acc = 0;
  int            checks = 0;
  int            failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs already driven at the negedge; check, update model, advance.
  task automatic tick();
    logic [DW-1:0] d;
    #1;
    chk("init_done", init_done, init_exp);
    chk("req_ready", req_ready, init_exp && (exp_q.size() < FD));
    chk("rsp_valid", rsp_valid, exp_q.size() > 0 && cyc >= exp_q[0].cyc + 2);
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        chk("rsp_rdata", rsp_rdata, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
    if (req_valid && req_ready) begin
      n_acc++;
      chk("acc_cs", sram_cs, 1'b1);
      chk("acc_we", sram_we, req_we);
      chk("acc_addr", sram_addr, req_addr);
      chk("acc_wdata", sram_wdata, req_wdata);
      chk("acc_be", sram_wbyteenable, req_we ? req_be : '0);
      if (req_we) begin
        d = ref_mem[req_addr];
        for (int b = 0; b < BW; b++) if (req_be[b]) d[8*b +: 8] = req_wdata[8*b +: 8];
        ref_mem[req_addr] = d;
      end else begin
        exp_q.push_back('{data: ref_mem[req_addr], cyc: cyc});
      end
    end else begin
      chk("idle_cs", sram_cs, 1'b0);
      chk("idle_ctl", {sram_we, sram_addr, sram_wbyteenable}, '0);
      chk("idle_wdata", sram_wdata, '0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds rst across one edge and checks the reset values; returns at negedge+1 with rst low.
  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_sram_cs", sram_cs, 1'b0);
    chk("rst_sram_bus", {sram_we, sram_addr, sram_wbyteenable}, '0);
    chk("rst_sram_wdata", sram_wdata, '0);
    exp_q.delete();
    init_exp = 1'b0;
    rst = 1'b0;
  endtask

`ifdef HPDCACHE_SRAM_INIT_EN
  task automatic run_sweep(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("sweep_cs", sram_cs, 1'b1);
      chk("sweep_we", sram_we, 1'b1);
      chk("sweep_addr", sram_addr, AW'(i));
      chk("sweep_wdata", sram_wdata, '0);
      chk("sweep_be", sram_wbyteenable, '1);
      chk("sweep_req_ready", req_ready, 1'b0);
      chk("sweep_init_done", init_done, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
  endtask
`endif

  task automatic finish_init();
`ifdef HPDCACHE_SRAM_INIT_EN
    run_sweep(DEP);
    for (int i = 0; i < DEP; i++) ref_mem[i] = '0;
`endif
    init_exp = 1'b1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), '0);
  endtask

  initial begin
    int base;
    for (int i = 0; i < DEP; i++) begin
      seed[i]    = $urandom;
      ref_mem[i] = seed[i];
    end
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    do_reset();
    finish_init();

`ifndef HPDCACHE_SRAM_INIT_EN
    // First cycle out of reset: a read must already be accepted.
    base = n_acc;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    tick();
    chk("first_read_acc", 32'(n_acc - base), 32'd1);
    drain();
`endif

    // Partial-byte write then read-back with 2-cycle latency.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 32'hA5A5_A5A5; req_be = 4'b0011;
    rsp_ready = 1'b1;
    tick();
    req_we = 1'b0; req_wdata = '0; req_be = '0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();

    // Back-to-back reads with continuous rsp_ready.
    base = n_acc;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i);
      tick();
    end
    chk("cont_accepts", 32'(n_acc - base), 32'd8);
    drain();

    // Backpressure: only FD reads fit while rsp_ready is low.
    base = n_acc;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(n_acc - base);
      tick();
    end
    chk("bp_accepts", 32'(n_acc - base), 32'd3);
    #1;
    chk("bp_req_ready", req_ready, 1'b0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && (n_acc - base) < 5; i++) begin
      req_valid = 1'b1; req_addr = AW'(n_acc - base);
      tick();
    end
    chk("bp_total", 32'(n_acc - base), 32'd5);
    drain();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = AW'($urandom_range(0, DEP - 1));
      req_wdata = $urandom;
      req_be    = BW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Reset with responses queued and a read in flight.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i + 8);
      tick();
    end
    do_reset();
`ifdef HPDCACHE_SRAM_INIT_EN
    run_sweep(7);
    #1;
    chk("sweep_at7", sram_addr, AW'(7));
    do_reset();
`endif
    finish_init();
    base = n_acc;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i * 3);
      tick();
    end
    chk("post_rst_accepts", 32'(n_acc - base), 32'd4);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
